k423_ex_lsu_seq: RTL and testbench

Parametrised, sequential load/store unit for the k423 EX stage. It accepts one memory operation at a time from EX and aligns write data and byte strobes to the bus lanes. It drives a valid/ready request channel and a valid-only response channel, optionally splitting lane-crossing accesses into two bus transfers, and returns sign- or zero-extended load data (or status) to writeback.

---
 rtl/k423_ex_lsu_seq.sv | 174 +++++++++++++++++
 tb/tb_k423_ex_lsu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/k423_ex_lsu_seq.sv
// k423 EX-stage load/store unit: one operation at a time, lane-aligned valid/ready requests,
// optional two-transfer split of lane-crossing accesses, extended load data/status to writeback.
module k423_ex_lsu_seq #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_vld_i,
  output logic                 ex_rdy_o,
  input  logic                 ex_load_i,
  input  logic                 ex_store_i,
  input  logic                 ex_unsigned_i,
  input  logic [1:0]           ex_size_i,
  input  logic [XLEN-1:0]      ex_base_i,
  input  logic [XLEN-1:0]      ex_offset_i,
  input  logic [XLEN-1:0]      ex_wdata_i,
  output logic                 mem_req_vld_o,
  input  logic                 mem_req_rdy_i,
  output logic [XLEN/8-1:0]    mem_req_wen_o,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  output logic [XLEN-1:0]      mem_req_wdata_o,
  input  logic                 mem_rsp_vld_i,
  input  logic [XLEN-1:0]      mem_rsp_rdata_i,
  input  logic                 mem_rsp_err_i,
  output logic                 wb_vld_o,
  output logic [XLEN-1:0]      wb_rdata_o,
  output logic                 wb_err_o,
  output logic                 wb_misalign_o,
  output logic [ADDR_W-1:0]    wb_addr_o
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MW     = 2 * STRB_W;
  localparam int DW     = 2 * XLEN;

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE} state_t;
  state_t state_q, state_d;

  logic              load_q, unsigned_q, cross_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DW-1:0]     wdat_q;
  logic [MW-1:0]     strb_q;
  logic [XLEN-1:0]   rsp0_q;
  logic              wb_vld_q, wb_err_q, wb_mis_q;
  logic [XLEN-1:0]   wb_rdata_q;
  logic [ADDR_W-1:0] wb_addr_q;

  logic              accept, cross_in, enter_done;
  logic [XLEN-1:0]   sum;
  logic [ADDR_W-1:0] ea_in, line_addr;
  logic [OFF_W-1:0]  off_in;
  logic [1:0]        size_in;
  logic [DW-1:0]     wdat_in, lane_cat, shifted;
  logic [MW-1:0]     strb_in;
  logic [XLEN-1:0]   ext;
  logic              sgn;
  int                nb;
  logic              wb_err_d, wb_mis_d;
  logic [XLEN-1:0]   wb_rdata_d;
  logic [ADDR_W-1:0] wb_addr_d;

  always_comb begin
    accept   = ex_vld_i && (state_q == S_IDLE) && (ex_load_i || ex_store_i);
    sum      = ex_base_i + ex_offset_i;
    ea_in    = sum[ADDR_W-1:0];
    off_in   = ea_in[OFF_W-1:0];
    // A double on a 32-bit datapath is treated as a word.
    size_in  = (XLEN == 32 && ex_size_i == 2'd3) ? 2'd2 : ex_size_i;
    cross_in = (int'(off_in) + (1 << size_in)) > STRB_W;
    wdat_in  = {{XLEN{1'b0}}, ex_wdata_i} << (8 * int'(off_in));
    strb_in  = MW'((1 << (1 << size_in)) - 1) << off_in;
  end

  // Second lane holds the upper bytes of a split load; a single transfer sees zeros there.
  always_comb begin
    lane_cat = (state_q == S_RSP1) ? {mem_rsp_rdata_i, rsp0_q}
                                   : {{XLEN{1'b0}}, mem_rsp_rdata_i};
    shifted  = lane_cat >> (8 * int'(ea_q[OFF_W-1:0]));
    nb       = 1 << size_q;
    sgn      = !unsigned_q && shifted[8*nb-1];
    for (int i = 0; i < XLEN; i++) begin
      ext[i] = (i < 8 * nb) ? shifted[i] : sgn;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cross_in && MISALIGN_SPLIT == 0) ? S_DONE : S_REQ0;
      S_REQ0: if (mem_req_rdy_i) state_d = S_RSP0;
      S_RSP0: if (mem_rsp_vld_i) state_d = (!mem_rsp_err_i && cross_q) ? S_REQ1 : S_DONE;
      S_REQ1: if (mem_req_rdy_i) state_d = S_RSP1;
      S_RSP1: if (mem_rsp_vld_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // DONE is only reached from IDLE when the access is rejected as misaligned.
  always_comb begin
    enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    wb_mis_d   = (state_q == S_IDLE);
    wb_err_d   = !wb_mis_d && mem_rsp_err_i;
    wb_rdata_d = (load_q && !wb_mis_d && !wb_err_d) ? ext : '0;
    wb_addr_d  = wb_mis_d ? ea_in : ea_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      load_q     <= 1'b0;
      unsigned_q <= 1'b0;
      cross_q    <= 1'b0;
      size_q     <= 2'd0;
      ea_q       <= '0;
      wdat_q     <= '0;
      strb_q     <= '0;
      rsp0_q     <= '0;
      wb_vld_q   <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        load_q     <= ex_load_i;
        unsigned_q <= ex_unsigned_i;
        cross_q    <= cross_in;
        size_q     <= size_in;
        ea_q       <= ea_in;
        wdat_q     <= wdat_in;
        strb_q     <= strb_in;
      end
      if (state_q == S_RSP0 && mem_rsp_vld_i) rsp0_q <= mem_rsp_rdata_i;
      wb_vld_q <= enter_done;
      if (enter_done) begin
        wb_err_q   <= wb_err_d;
        wb_mis_q   <= wb_mis_d;
        wb_rdata_q <= wb_rdata_d;
        wb_addr_q  <= wb_addr_d;
      end
    end
  end

  assign line_addr = {ea_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    mem_req_addr_o  = '0;
    mem_req_wen_o   = '0;
    mem_req_wdata_o = '0;
    if (state_q == S_REQ0) begin
      mem_req_addr_o  = line_addr;
      mem_req_wen_o   = load_q ? '0 : strb_q[STRB_W-1:0];
      mem_req_wdata_o = wdat_q[XLEN-1:0];
    end else if (state_q == S_REQ1) begin
      mem_req_addr_o  = line_addr + ADDR_W'(STRB_W);
      mem_req_wen_o   = load_q ? '0 : strb_q[MW-1:STRB_W];
      mem_req_wdata_o = wdat_q[DW-1:XLEN];
    end
  end

  assign ex_rdy_o      = (state_q == S_IDLE);
  assign mem_req_vld_o = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign wb_vld_o      = wb_vld_q;
  assign wb_rdata_o    = wb_rdata_q;
  assign wb_err_o      = wb_err_q;
  assign wb_misalign_o = wb_mis_q;
  assign wb_addr_o     = wb_addr_q;

endmodule

// File: tb/tb_k423_ex_lsu_seq.sv
// Directed bench for k423_ex_lsu_seq: a split-enabled instance for bus traffic and a
// split-disabled instance for the misalignment path.
module tb_k423_ex_lsu_seq;
  logic        clk, rst;
  logic        ex_vld, ex_vld_ns, ex_load, ex_store, ex_uns;
  logic [1:0]  ex_size;
  logic [31:0] ex_base, ex_offset, ex_wdata;
  logic        mem_req_rdy, mem_rsp_vld, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  logic        ex_rdy, req_vld, wb_vld, wb_err, wb_mis;
  logic [3:0]  req_wen;
  logic [31:0] req_addr, req_wdata, wb_rdata, wb_addr;
  logic        ex_rdy_n, req_vld_n, wb_vld_n, wb_err_n, wb_mis_n;
  logic [3:0]  req_wen_n;
  logic [31:0] req_addr_n, req_wdata_n, wb_rdata_n, wb_addr_n;

  int n_cmp = 0;
  int n_bad = 0;

  k423_ex_lsu_seq #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .ex_vld_i(ex_vld), .ex_rdy_o(ex_rdy),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_unsigned_i(ex_uns), .ex_size_i(ex_size),
    .ex_base_i(ex_base), .ex_offset_i(ex_offset), .ex_wdata_i(ex_wdata),
    .mem_req_vld_o(req_vld), .mem_req_rdy_i(mem_req_rdy), .mem_req_wen_o(req_wen),
    .mem_req_addr_o(req_addr), .mem_req_wdata_o(req_wdata),
    .mem_rsp_vld_i(mem_rsp_vld), .mem_rsp_rdata_i(mem_rsp_rdata), .mem_rsp_err_i(mem_rsp_err),
    .wb_vld_o(wb_vld), .wb_rdata_o(wb_rdata), .wb_err_o(wb_err),
    .wb_misalign_o(wb_mis), .wb_addr_o(wb_addr)
  );

  k423_ex_lsu_seq #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_ns (
    .clk_i(clk), .rst_i(rst), .ex_vld_i(ex_vld_ns), .ex_rdy_o(ex_rdy_n),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_unsigned_i(ex_uns), .ex_size_i(ex_size),
    .ex_base_i(ex_base), .ex_offset_i(ex_offset), .ex_wdata_i(ex_wdata),
    .mem_req_vld_o(req_vld_n), .mem_req_rdy_i(mem_req_rdy), .mem_req_wen_o(req_wen_n),
    .mem_req_addr_o(req_addr_n), .mem_req_wdata_o(req_wdata_n),
    .mem_rsp_vld_i(mem_rsp_vld), .mem_rsp_rdata_i(mem_rsp_rdata), .mem_rsp_err_i(mem_rsp_err),
    .wb_vld_o(wb_vld_n), .wb_rdata_o(wb_rdata_n), .wb_err_o(wb_err_n),
    .wb_misalign_o(wb_mis_n), .wb_addr_o(wb_addr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic uns, input logic [1:0] sz,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    ex_vld = 1'b1; ex_load = ld; ex_store = st; ex_uns = uns; ex_size = sz;
    ex_base = base; ex_offset = off; ex_wdata = wd;
    tick();
    ex_vld = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    mem_rsp_vld = 1'b1; mem_rsp_rdata = d; mem_rsp_err = e;
    tick();
    mem_rsp_vld = 1'b0; mem_rsp_err = 1'b0;
  endtask

  task automatic run_single(input string tg, input logic ld, input logic st, input logic uns,
                            input logic [1:0] sz, input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] wd, input logic [31:0] rsp,
                            input logic [31:0] exp_addr, input logic [3:0] exp_wen,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    logic [31:0] ea;
    ea = base + off;
    issue(ld, st, uns, sz, base, off, wd);
    chk({tg, ".req_vld"}, req_vld, 1);
    chk({tg, ".req_addr"}, req_addr, exp_addr);
    chk({tg, ".req_wen"}, req_wen, exp_wen);
    chk({tg, ".req_wdata"}, req_wdata, exp_wdata);
    tick();
    chk({tg, ".req_drop"}, req_vld, 0);
    respond(rsp, 1'b0);
    chk({tg, ".wb_vld"}, wb_vld, 1);
    chk({tg, ".wb_rdata"}, wb_rdata, exp_rdata);
    chk({tg, ".wb_err"}, wb_err, 0);
    chk({tg, ".wb_mis"}, wb_mis, 0);
    chk({tg, ".wb_addr"}, wb_addr, ea);
    tick();
    chk({tg, ".wb_pulse"}, wb_vld, 0);
    chk({tg, ".ex_rdy"}, ex_rdy, 1);
  endtask

  task automatic run_split(input string tg, input logic ld, input logic st,
                           input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                           input logic [31:0] rsp0, input logic [31:0] rsp1,
                           input logic [31:0] a0, input logic [3:0] wen0, input logic [31:0] wd0,
                           input logic [31:0] a1, input logic [3:0] wen1, input logic [31:0] wd1,
                           input logic [31:0] exp_rdata);
    issue(ld, st, 1'b0, 2'd2, base, off, wd);
    chk({tg, ".a0"}, req_addr, a0);
    chk({tg, ".wen0"}, req_wen, wen0);
    chk({tg, ".wd0"}, req_wdata, wd0);
    tick();
    respond(rsp0, 1'b0);
    chk({tg, ".req1_vld"}, req_vld, 1);
    chk({tg, ".a1"}, req_addr, a1);
    chk({tg, ".wen1"}, req_wen, wen1);
    chk({tg, ".wd1"}, req_wdata, wd1);
    tick();
    chk({tg, ".wait1"}, {req_vld, wb_vld}, 0);
    respond(rsp1, 1'b0);
    chk({tg, ".wb_vld"}, wb_vld, 1);
    chk({tg, ".wb_rdata"}, wb_rdata, exp_rdata);
    chk({tg, ".wb_addr"}, wb_addr, base + off);
    tick();
    chk({tg, ".wb_pulse"}, wb_vld, 0);
  endtask

  initial begin
    rst = 1'b1; ex_vld = 1'b0; ex_vld_ns = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_uns = 1'b0; ex_size = 2'd0; ex_base = '0; ex_offset = '0; ex_wdata = '0;
    mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp_err = 1'b0; mem_rsp_rdata = '0;
    tick(); tick();
    chk("rst.ex_rdy", ex_rdy, 1);
    chk("rst.req", {req_vld, req_wen, req_addr, req_wdata}, 0);
    chk("rst.wb", {wb_vld, wb_err, wb_mis, wb_rdata, wb_addr}, 0);
    rst = 1'b0;
    tick();

    // offer with no type bit is ignored
    ex_vld = 1'b1;
    tick();
    ex_vld = 1'b0;
    chk("noop.req_vld", req_vld, 0);
    chk("noop.ex_rdy", ex_rdy, 1);

    run_single("lw",  1, 0, 0, 2'd2, 32'h1000, 32'h4, 32'h0, 32'hDEADBEEF,
               32'h1004, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_single("lb",  1, 0, 0, 2'd0, 32'h1000, 32'h3, 32'h0, 32'h80123456,
               32'h1000, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_single("lbu", 1, 0, 1, 2'd0, 32'h1000, 32'h3, 32'h0, 32'h80123456,
               32'h1000, 4'b0000, 32'h0, 32'h00000080);
    run_single("lh",  1, 0, 0, 2'd1, 32'h1000, 32'h2, 32'h0, 32'hF00D1234,
               32'h1000, 4'b0000, 32'h0, 32'hFFFFF00D);
    run_single("sh",  0, 1, 0, 2'd1, 32'h2000, 32'h1, 32'h0000ABCD, 32'h12345678,
               32'h2000, 4'b0110, 32'h00ABCD00, 32'h0);
    // double on a 32-bit unit behaves as a word
    run_single("ld32", 1, 0, 0, 2'd3, 32'h1000, 32'h8, 32'h0, 32'h87654321,
               32'h1008, 4'b0000, 32'h0, 32'h87654321);

    run_split("sw_x", 0, 1, 32'h3000, 32'h3, 32'h11223344, 32'h0, 32'h0,
              32'h3000, 4'b1000, 32'h44000000, 32'h3004, 4'b0111, 32'h00112233, 32'h0);
    run_split("lw_x", 1, 0, 32'h3000, 32'h2, 32'h0, 32'hAABB0000, 32'h0000CCDD,
              32'h3000, 4'b0000, 32'h0, 32'h3004, 4'b0000, 32'h0, 32'hCCDDAABB);

    // wrap of the second transfer address, with the bus stalling it
    issue(1, 0, 0, 2'd2, 32'hFFFFFFF0, 32'h0E, 32'h0);
    chk("wrap.a0", req_addr, 32'hFFFFFFFC);
    tick();
    respond(32'hBEEF0000, 1'b0);
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wrap.stall", {req_vld, req_wen, req_addr, req_wdata}, {1'b1, 4'b0000, 32'h0, 32'h0});
      tick();
    end
    mem_req_rdy = 1'b1;
    chk("wrap.held", {req_vld, req_addr}, {1'b1, 32'h0});
    tick();
    respond(32'h0000CAFE, 1'b0);
    chk("wrap.wb", {wb_vld, wb_err, wb_rdata, wb_addr}, {1'b1, 1'b0, 32'hCAFEBEEF, 32'hFFFFFFFE});
    tick();

    // misaligned word with splitting disabled
    ex_vld_ns = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_uns = 1'b0; ex_size = 2'd2;
    ex_base = 32'h3000; ex_offset = 32'h2;
    tick();
    ex_vld_ns = 1'b0;
    chk("mis.wb_vld", wb_vld_n, 1);
    chk("mis.flag", wb_mis_n, 1);
    chk("mis.addr", wb_addr_n, 32'h3002);
    chk("mis.rdata_err", {wb_rdata_n, wb_err_n}, 0);
    chk("mis.no_req", req_vld_n, 0);
    tick();
    chk("mis.pulse", {wb_vld_n, req_vld_n, ex_rdy_n}, 3'b001);

    // error on first half of a split load suppresses the second transfer
    issue(1, 0, 0, 2'd2, 32'h3000, 32'h2, 32'h0);
    tick();
    respond(32'h12345678, 1'b1);
    chk("err.wb", {wb_vld, wb_err, wb_rdata}, {1'b1, 1'b1, 32'h0});
    chk("err.no_req1", req_vld, 0);
    tick();
    chk("err.idle", {wb_vld, req_vld, ex_rdy}, 3'b001);

    // reset in RSP0 aborts; late response ignored
    issue(1, 0, 0, 2'd2, 32'h1000, 32'h4, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid.ex_rdy", ex_rdy, 1);
    #1;
    rst = 1'b0;
    respond(32'h55555555, 1'b0);
    chk("rst_mid.no_wb", {wb_vld, req_vld}, 0);
    tick();
    chk("rst_mid.quiet", {wb_vld, req_vld, ex_rdy}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
